// File: rtl/secded_pkg.sv
// Shared types and constants for the SECDED(8,4) memory scrubber.
// The states, the error classes and the codeword bit positions all live here.
package secded_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CHK  = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_SINGLE = 2'd1,
        ERR_DOUBLE = 2'd2,
        ERR_PARITY = 2'd3
    } err_e;

    // Bit index n holds Hamming position n+1; bit 7 is the overall even parity.
    localparam int unsigned P1_BIT  = 0;
    localparam int unsigned P2_BIT  = 1;
    localparam int unsigned D0_BIT  = 2;
    localparam int unsigned P4_BIT  = 3;
    localparam int unsigned D1_BIT  = 4;
    localparam int unsigned D2_BIT  = 5;
    localparam int unsigned D3_BIT  = 6;
    localparam int unsigned PAR_BIT = 7;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/secded_dec8.sv
// Combinational SECDED(8,4) decoder: classifies a codeword and produces the
// corrected codeword and its 4 data bits.
module secded_dec8
    import secded_pkg::*;
(
    input  logic [7:0] cw_i,
    output logic [7:0] corr_o,
    output logic [3:0] data_o,
    output logic [1:0] err_o
);

    logic [2:0] syn;
    logic       par_err;

    always_comb begin
        syn[0]  = cw_i[P1_BIT] ^ cw_i[D0_BIT] ^ cw_i[D1_BIT] ^ cw_i[D3_BIT];
        syn[1]  = cw_i[P2_BIT] ^ cw_i[D0_BIT] ^ cw_i[D2_BIT] ^ cw_i[D3_BIT];
        syn[2]  = cw_i[P4_BIT] ^ cw_i[D1_BIT] ^ cw_i[D2_BIT] ^ cw_i[D3_BIT];
        par_err = ^cw_i;

        corr_o = cw_i;
        err_o  = ERR_NONE;
        if (syn != 3'd0 && par_err) begin
            // Syndrome names the 1-based position of the flipped bit.
            err_o  = ERR_SINGLE;
            corr_o = cw_i ^ (8'h01 << (syn - 3'd1));
        end else if (syn != 3'd0) begin
            err_o = ERR_DOUBLE;
        end else if (par_err) begin
            err_o           = ERR_PARITY;
            corr_o[PAR_BIT] = ~cw_i[PAR_BIT];
        end

        data_o = {corr_o[D3_BIT], corr_o[D2_BIT], corr_o[D1_BIT], corr_o[D0_BIT]};
    end

endmodule

// File: rtl/secded_scrub_ctrl.sv
// Memory scrubber: reads every word once per pass, writes back correctable
// words, counts errors. Optional o_irq output under SECDED_SCRUB_IRQ_EN.
module secded_scrub_ctrl
    import secded_pkg::*;
#(
    parameter int AW = 4,
    parameter int CW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_abort,
    output logic          o_busy,
    output logic          o_done,
    output logic [AW-1:0] o_mem_addr,
    output logic          o_mem_rd,
    input  logic [7:0]    i_mem_rdata,
    output logic          o_mem_wr,
    output logic [7:0]    o_mem_wdata,
    output logic [7:0]    o_cnt_1bit,
    output logic [7:0]    o_cnt_2bit,
    output logic [AW-1:0] o_last_2bit_addr,
`ifdef SECDED_SCRUB_IRQ_EN
    output logic          o_irq,
`endif
    output logic [2:0]    o_dbg_state,
    output logic [3:0]    o_dbg_data
);

    generate
        if (CW != 8) begin : g_cw_check
            $error("secded_scrub_ctrl: CW must be 8");
        end
    endgenerate

    localparam logic [AW-1:0] ADDR_MAX = '1;

    // Handshake: o_mem_rd in cycle N means i_mem_rdata is valid in cycle N+1;
    // o_mem_wr commits o_mem_wdata to o_mem_addr in the same cycle. No stalls.
    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    cnt1_q, cnt1_d;
    logic [7:0]    cnt2_q, cnt2_d;
    logic [AW-1:0] last2_q, last2_d;
    logic [7:0]    wdata_q, wdata_d;

    logic [7:0] dec_corr;
    logic [3:0] dec_data;
    logic [1:0] dec_err_raw;
    err_e       dec_err;

    secded_dec8 u_dec (
        .cw_i   (i_mem_rdata),
        .corr_o (dec_corr),
        .data_o (dec_data),
        .err_o  (dec_err_raw)
    );

    assign dec_err = err_e'(dec_err_raw);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt1_q  <= '0;
            cnt2_q  <= '0;
            last2_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt1_q  <= cnt1_d;
            cnt2_q  <= cnt2_d;
            last2_q <= last2_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt1_d  = cnt1_q;
        cnt2_d  = cnt2_q;
        last2_d = last2_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (i_start && !i_abort) begin
                    state_d = S_RD;
                    addr_d  = '0;
                    cnt1_d  = '0;
                    cnt2_d  = '0;
                end
            end
            S_RD: begin
                state_d = i_abort ? S_IDLE : S_CHK;
            end
            S_CHK: begin
                // An aborted check leaves the counters exactly as they were.
                if (i_abort) begin
                    state_d = S_IDLE;
                end else if (dec_err == ERR_SINGLE || dec_err == ERR_PARITY) begin
                    wdata_d = dec_corr;
                    cnt1_d  = sat_inc8(cnt1_q);
                    state_d = S_WR;
                end else begin
                    if (dec_err == ERR_DOUBLE) begin
                        cnt2_d  = sat_inc8(cnt2_q);
                        last2_d = addr_q;
                    end
                    if (addr_q == ADDR_MAX) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr_q + AW'(1);
                        state_d = S_RD;
                    end
                end
            end
            S_WR: begin
                if (i_abort) begin
                    state_d = S_IDLE;
                end else if (addr_q == ADDR_MAX) begin
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q + AW'(1);
                    state_d = S_RD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_busy           = (state_q == S_RD) || (state_q == S_CHK) || (state_q == S_WR);
    assign o_done           = (state_q == S_DONE);
    assign o_mem_rd         = (state_q == S_RD);
    assign o_mem_wr         = (state_q == S_WR);
    assign o_mem_addr       = addr_q;
    assign o_mem_wdata      = wdata_q;
    assign o_cnt_1bit       = cnt1_q;
    assign o_cnt_2bit       = cnt2_q;
    assign o_last_2bit_addr = last2_q;
    assign o_dbg_state      = state_q;
    assign o_dbg_data       = dec_data;

`ifdef SECDED_SCRUB_IRQ_EN
    assign o_irq = (state_q == S_CHK) && (dec_err == ERR_DOUBLE);
`endif

endmodule

// File: doc/secded_scrub_ctrl.md
SECDED_SCRUB_CTRL -- requirements
Module: secded_scrub_ctrl

Interface
REQ-001 SHALL have parameter AW, default 4, meaning the address width; the scrubbed memory depth is 2**AW words.
REQ-002 SHALL have parameter CW, default 8, meaning the codeword width; it is fixed at 8 and any other value is a elaboration error.
REQ-003 SHALL have port i_clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst  in  1  reset; one clock, asynchronous, active-high.
REQ-005 SHALL have port i_start  in  1  level-sampled request to begin one scrub pass.
REQ-006 SHALL have port i_abort  in  1  terminates the current pass.
REQ-007 SHALL have port o_busy  out  1  high while a pass is in progress.
REQ-008 SHALL have port o_done  out  1  one-cycle pulse when a pass completes.
REQ-009 SHALL have port o_mem_addr  out  AW  memory address.
REQ-010 SHALL have port o_mem_rd  out  1  read strobe; i_mem_rdata is valid on the next cycle.
REQ-011 SHALL have port i_mem_rdata  in  8  read codeword.
REQ-012 SHALL have port o_mem_wr  out  1  write strobe.
REQ-013 SHALL have port o_mem_wdata  out  8  corrected codeword.
REQ-014 SHALL have port o_cnt_1bit  out  8  count of corrected errors, covering both single-bit and parity-bit errors.
REQ-015 SHALL have port o_cnt_2bit  out  8  count of uncorrectable errors.
REQ-016 SHALL have port o_last_2bit_addr  out  AW  address of the most recent uncorrectable word.

Function
REQ-017 SHALL use this codeword layout: bits [6:0] hold Hamming(7,4) positions 1..7, with bit0 = position 1; data[0..3] = positions 3, 5, 6, 7; bit7 = even overall parity.
REQ-018 SHALL classify a codeword as follows:
- syndrome nonzero and parity mismatch: 1-bit error, flip the syndrome position;
- syndrome nonzero and parity OK: 2-bit error;
- syndrome zero and parity mismatch: parity error, flip bit7.
REQ-019 SHALL implement FSM states IDLE, RD, CHK, WR and DONE.
REQ-020 SHALL make the transition IDLE->RD when i_start=1; on this transition, address and both counters clear to 0.
REQ-021 SHALL assert o_mem_rd=1 in state RD and then move to CHK.
REQ-022 SHALL decode i_mem_rdata in CHK; if the word is correctable it goes to WR, otherwise it advances.
REQ-023 SHALL assert o_mem_wr=1 in WR, with o_mem_wdata equal to the corrected codeword registered in CHK, and then advance.
REQ-024 SHALL advance as follows: if the address equals 2**AW-1, go to DONE; otherwise increment the address and go to RD.
REQ-025 SHALL assert o_done=1 for exactly one cycle in DONE and then return to IDLE.
REQ-026 SHALL hold o_busy=1 in states RD, CHK and WR.
REQ-027 SHALL take 2 cycles per clean word and 3 cycles per corrected word; a pass of all-clean words takes 2*2**AW+1 cycles from start to o_done.
REQ-028 SHALL never write back a word with a 2-bit error; such a word increments o_cnt_2bit and updates o_last_2bit_addr.
REQ-029 SHALL saturate both counters at 255 with no wrap-around.
REQ-030 SHALL ignore i_start while busy.
REQ-031 SHALL, when i_abort=1 in RD, CHK, WR or DONE, go to IDLE on the next edge:
- no o_done pulse;
- counters retained;
- a WR-state write is still issued in that cycle;
- abort has priority over start.
REQ-032 SHALL drive o_mem_rd, o_mem_wr and o_done as Moore outputs decoded from state only.

Reset
REQ-033 SHALL, on asynchronous i_rst=1, immediately place the FSM in IDLE and zero every output and register.
REQ-034 SHALL, when reset occurs mid-pass, never produce a partial write after reset is released.

Configuration
REQ-035 SHALL, with SECDED_SCRUB_IRQ_EN defined, include output port o_irq (1 bit), which pulses for one cycle in the CHK cycle that classifies a 2-bit error and resets to 0.
REQ-036 SHALL, without SECDED_SCRUB_IRQ_EN, have no o_irq port and no associated logic.

Structure
REQ-037 SHALL place the state enum, the error-class enum (NONE/SINGLE/DOUBLE/PARITY) and the bit-position constants in package secded_pkg.
REQ-038 SHALL implement the combinational decoder as sub-module secded_dec8:
- input: 8-bit codeword;
- outputs: corrected codeword, 4-bit data, error class.

Verification
REQ-039 SHALL cover: AW=2, all four words valid encodings of 0x0/0x5/0xA/0xF, i_start pulse -> o_done at cycle 9, no o_mem_wr, both counters 0.
REQ-040 SHALL cover: word 1 with bit2 flipped -> o_mem_wr at address 1 with the original codeword, o_cnt_1bit=1, total 10 cycles.
REQ-041 SHALL cover: word 2 with bit7 flipped -> write of the restored codeword, o_cnt_1bit=1.
REQ-042 SHALL cover: word 3 with bits 0 and 4 flipped -> no write, o_cnt_2bit=1, o_last_2bit_addr=3, o_irq pulse when SECDED_SCRUB_IRQ_EN is defined.
REQ-043 SHALL cover: i_abort asserted in the second CHK -> IDLE next cycle, no o_done, counters held; i_start during busy -> ignored.
REQ-044 SHALL cover: 300 corrupted-word passes without clearing -> o_cnt_1bit stays at 255; i_rst asserted during WR -> all outputs 0 immediately.
